elbeth_exu: RTL and testbench
=============================

# elbeth_exu

Parametrised, handshaked execution unit for the ELBETH core. It replaces the purely combinational ALU stage with a registered unit of width XLEN. All base integer operations complete in one cycle. The RV32M-style multiply/divide operations run on an iterative radix-2 datapath. It sits between decode/operand-fetch and writeback, using valid/ready on both sides so that multi-cycle operations stall the pipeline.

## Interface
- XLEN, 32: operand/result width; must be a power of two, ≥ 8.
- MULDIV_EN, 1: 1 = multiply/divide ops implemented; 0 = those codes return 0 in one cycle.
- SHW, $clog2(XLEN): shift-amount width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous kill: abort in-flight op and drop the held result.
- in_valid  in  1  operands/operation presented.
- in_ready  out  1  unit can accept this cycle.
- operation  in  5  op code from the shared definitions header.
- data_a  in  XLEN  operand A (rs1).
- data_b  in  XLEN  operand B (rs2/imm).
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.
- busy  out  1  iterative op in progress.

## Operation
- Base ops (ADD, SUB, AND, OR, XOR, SLTU, SLT, SLL, SRL, SRA):
  - Computed combinationally.
  - Captured into the result register on acceptance (in_valid & in_ready).
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU return 0 or 1, zero-extended.
- Shifts use data_b[SHW-1:0] only; upper bits are ignored.
- MUL/MULH/MULHSU/MULHU:
  - Shift-add over XLEN iterations on magnitudes, 2·XLEN accumulator.
  - Sign fix-up in a FIX cycle.
  - MUL returns the low half; the others return the high half.
- DIV/DIVU/REM/REMU: restoring division over XLEN iterations on magnitudes, then sign fix-up in FIX.
  - Quotient sign is sign(a)^sign(b).
  - Remainder sign is sign(a).
- Divisor zero (short-circuit, no iteration):
  - DIV/DIVU → all-ones.
  - REM/REMU → data_a.
- Signed overflow (a = −2^(XLEN−1), b = −1; short-circuit):
  - DIV → a.
  - REM → 0.
- FSM states:
  - IDLE: accepting.
  - ITER: counter 0..XLEN−1.
  - FIX: one cycle.
  - Transitions: IDLE→ITER on accepting a non-short-circuit muldiv op; ITER→FIX when counter = XLEN−1; FIX→IDLE, loading the result register.
- in_ready = (state == IDLE) & (!out_valid | out_ready). Acceptance and drain in the same cycle are legal (back-to-back).
- Output register holds result stable while out_valid & !out_ready.
- Unknown op code: result 0, one-cycle latency.

## Timing
- Reset values:
  - out_valid = 0, result = 0, busy = 0, state = IDLE, counter = 0.
  - in_ready is 1 after reset release.
- Base op accepted in cycle N → out_valid and result visible in N+1.
- Muldiv op accepted in N:
  - busy = 1 in N+1 .. N+XLEN+1.
  - ITER occupies N+1..N+XLEN, FIX occupies N+XLEN+1.
  - out_valid in N+XLEN+2, so latency is XLEN+2 (34 for XLEN = 32).
- Short-circuit divide: out_valid in N+1.
- in_ready is 0 throughout ITER/FIX.
- flush:
  - Next cycle: state = IDLE, busy = 0, out_valid = 0.
  - An input presented in the same cycle as flush is not accepted (in_ready is forced 0 while flush = 1).
  - flush has priority over out_ready and over FIX completion.
- rst_n low mid-iteration clears everything immediately; no partial result is ever emitted.

## Structure
- Shared definitions header (elbeth_definitions.v) holds:
  - The 5-bit op codes: existing ten base codes plus MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - An IS_MULDIV decode macro.
- Sub-module elbeth_muldiv_iter:
  - Contains the counter, accumulator, divisor/multiplicand registers and the start/done handshake.
  - Instantiated under generate when MULDIV_EN = 1.
- Top level holds: base-op combinational logic, the FSM, the short-circuit detection, and the output register.

## Test plan
- Reset/base ops:
  - Release reset; ADD 0xFFFFFFFF + 1 → result 0x00000000 one cycle later.
  - SRA 0x80000000 by data_b = 0x21 → 0xC0000000 (shamt 1).
- Back-to-back:
  - Five consecutive base ops with out_ready held 1 → one result per cycle, in order, in_ready never low.
- Multiply:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
  - MULHU same operands → 0xFFFFFFFE.
  - Each arrives at exactly N+34, with busy high for 33 cycles.
- Divide corners:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at N+1.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 5 / 0 → 0xFFFFFFFF at N+1.
  - REMU 5 / 0 → 5.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after a MUL result → result stable, in_ready = 0.
  - Release → next op accepted in the same cycle the result is taken.
- Flush/reset mid-op:
  - Assert flush in iteration 10 of DIV → no out_valid, in_ready = 1 next cycle.
  - Repeat with rst_n pulse → all outputs 0 asynchronously.

Source files
------------

// File: rtl/elbeth_pkg.sv
// elbeth_pkg: shared definitions for the ELBETH execution unit.
// Holds the 5-bit operation codes, the unit FSM state type and small
// op-class decode helpers used by the top level.
package elbeth_pkg;

  // Base integer operation codes
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLTU   = 5'd5;
  localparam logic [4:0] OP_SLT    = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  // Multiply / divide operation codes
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // True for any multiply or divide code
  function automatic logic is_muldiv(input logic [4:0] op);
    is_muldiv = (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  // True for divide/remainder codes only
  function automatic logic is_div(input logic [4:0] op);
    is_div = (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/elbeth_muldiv_iter.sv
// elbeth_muldiv_iter: iterative radix-2 multiply / restoring-divide core.
// Works on unsigned magnitudes; sign fix-up is done by the caller.
// Ports: i_clk, i_rst_n (async active-low), i_flush (sync clear),
//   i_start (load operands), i_step (perform one iteration),
//   i_is_div (select divide step), i_a_mag / i_b_mag (magnitudes),
//   o_done (last iteration this cycle), o_acc ({hi, lo} accumulator).
// After XLEN steps o_acc holds the 2*XLEN product, or {remainder, quotient}.
module elbeth_muldiv_iter
  import elbeth_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a_mag,
  input  logic [XLEN-1:0]   i_b_mag,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_acc
);

  logic [SHW-1:0]    r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_acc_nxt;

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
    // Partial remainder shifted left with the next dividend bit brought in
    w_trial = r_acc[2*XLEN-1:XLEN-1];
    w_diff  = w_trial - {1'b0, r_opnd};
    if (i_is_div) begin
      if (!w_diff[XLEN]) begin
        w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      // Low half holds the remaining multiplier bits; carry lands in bit 2*XLEN-1
      if (r_acc[0]) begin
        w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
      end else begin
        w_acc_nxt = {1'b0, r_acc[2*XLEN-1:1]};
      end
    end
  end

  assign o_done = i_step && (r_cnt == SHW'(XLEN - 1));
  assign o_acc  = r_acc;

  // Counter, accumulator and operand registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= {SHW{1'b0}};
      r_acc  <= {(2*XLEN){1'b0}};
      r_opnd <= {XLEN{1'b0}};
    end else if (i_flush) begin
      r_cnt  <= {SHW{1'b0}};
    end else if (i_start) begin
      r_cnt  <= {SHW{1'b0}};
      r_acc  <= {{XLEN{1'b0}}, i_a_mag};
      r_opnd <= i_b_mag;
    end else if (i_step) begin
      r_acc  <= w_acc_nxt;
      r_cnt  <= o_done ? {SHW{1'b0}} : (r_cnt + {{(SHW-1){1'b0}}, 1'b1});
    end else begin
      r_cnt  <= r_cnt;
    end
  end

endmodule

// File: rtl/elbeth_exu.sv
// elbeth_exu: registered, valid/ready handshaked execution unit.
// Base ops finish in one cycle; multiply/divide use elbeth_muldiv_iter
// (IDLE -> ITER x XLEN -> FIX), latency XLEN+2. Divide-by-zero and signed
// overflow short-circuit in one cycle.
// Ports: clk, rst_n (async active-low), flush (sync kill), in_valid/in_ready,
//   operation (5-bit code), data_a, data_b, out_valid/out_ready,
//   result (registered), busy (iterative op in progress).
module elbeth_exu
  import elbeth_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int MULDIV_EN = 1,
  localparam int SHW       = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      operation,
  input  logic [XLEN-1:0] data_a,
  input  logic [XLEN-1:0] data_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic            MD_ON    = (MULDIV_EN != 32'sd0);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state, w_state_nxt;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_op;
  logic              r_neg_q, r_neg_r;

  logic              w_accept, w_start, w_step, w_fix, w_done;
  logic              w_signed_a, w_signed_b, w_a_neg, w_b_neg;
  logic              w_div_zero, w_ovf, w_short, w_multi;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_single_res, w_fix_res;
  logic [XLEN-1:0]   w_quot, w_rem;
  logic [2*XLEN-1:0] w_acc, w_prod;

  assign in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready) && !flush;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = (r_state != ST_IDLE);
  assign w_shamt   = data_b[SHW-1:0];

  // Operand sign handling and short-circuit detection
  always_comb begin
    w_signed_a = (operation == OP_MULH) || (operation == OP_MULHSU) ||
                 (operation == OP_DIV)  || (operation == OP_REM);
    w_signed_b = (operation == OP_MULH) || (operation == OP_DIV) ||
                 (operation == OP_REM);
    w_a_neg    = w_signed_a && data_a[XLEN-1];
    w_b_neg    = w_signed_b && data_b[XLEN-1];
    w_a_mag    = w_a_neg ? (ZERO - data_a) : data_a;
    w_b_mag    = w_b_neg ? (ZERO - data_b) : data_b;
    w_div_zero = (data_b == ZERO);
    w_ovf      = ((operation == OP_DIV) || (operation == OP_REM)) &&
                 (data_a == MIN_NEG) && (data_b == ONES);
    w_short    = is_div(operation) && (w_div_zero || w_ovf);
    w_multi    = MD_ON && is_muldiv(operation) && !w_short;
  end

  // Single-cycle results: base ops, short-circuit divides, unknown codes
  always_comb begin
    w_single_res = ZERO;
    case (operation)
      OP_ADD:  w_single_res = data_a + data_b;
      OP_SUB:  w_single_res = data_a - data_b;
      OP_AND:  w_single_res = data_a & data_b;
      OP_OR:   w_single_res = data_a | data_b;
      OP_XOR:  w_single_res = data_a ^ data_b;
      OP_SLTU: w_single_res = {{(XLEN-1){1'b0}}, (data_a < data_b)};
      OP_SLT:  w_single_res = {{(XLEN-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
      OP_SLL:  w_single_res = data_a << w_shamt;
      OP_SRL:  w_single_res = data_a >> w_shamt;
      OP_SRA:  w_single_res = $signed(data_a) >>> w_shamt;
      OP_DIV, OP_DIVU: begin
        if (MD_ON && w_div_zero) begin
          w_single_res = ONES;
        end else if (MD_ON && w_ovf) begin
          w_single_res = data_a;
        end else begin
          w_single_res = ZERO;
        end
      end
      OP_REM, OP_REMU: begin
        if (MD_ON && w_div_zero) begin
          w_single_res = data_a;
        end else begin
          w_single_res = ZERO;
        end
      end
      default: w_single_res = ZERO;
    endcase
  end

  // Sign fix-up of the iterative result, selected by the captured op
  always_comb begin
    w_prod    = r_neg_q ? ({(2*XLEN){1'b0}} - w_acc) : w_acc;
    w_quot    = r_neg_q ? (ZERO - w_acc[XLEN-1:0]) : w_acc[XLEN-1:0];
    w_rem     = r_neg_r ? (ZERO - w_acc[2*XLEN-1:XLEN]) : w_acc[2*XLEN-1:XLEN];
    w_fix_res = ZERO;
    case (r_op)
      OP_MUL:                        w_fix_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fix_res = w_quot;
      OP_REM, OP_REMU:               w_fix_res = w_rem;
      default:                       w_fix_res = ZERO;
    endcase
  end

  // FSM next state and iteration control; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_multi) begin
            w_state_nxt = ST_ITER;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ITER: begin
          w_step = 1'b1;
          if (w_done) begin
            w_state_nxt = ST_FIX;
          end else begin
            w_state_nxt = ST_ITER;
          end
        end
        ST_FIX: begin
          w_fix       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  generate
    if (MULDIV_EN != 32'sd0) begin : g_muldiv
      elbeth_muldiv_iter #(.XLEN(XLEN), .SHW(SHW)) u_iter (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_flush  (flush),
        .i_start  (w_start),
        .i_step   (w_step),
        .i_is_div (is_div(r_op)),
        .i_a_mag  (w_a_mag),
        .i_b_mag  (w_b_mag),
        .o_done   (w_done),
        .o_acc    (w_acc)
      );
    end else begin : g_no_muldiv
      assign w_done = 1'b0;
      assign w_acc  = {(2*XLEN){1'b0}};
    end
  endgenerate

  // State, output register and captured op context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= ZERO;
      r_op        <= 5'd0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_fix) begin
        r_out_valid <= 1'b1;
        r_result    <= w_fix_res;
      end else if (w_accept && !w_multi) begin
        r_out_valid <= 1'b1;
        r_result    <= w_single_res;
      end else if (out_ready) begin
        // Also covers accepting an iterative op: the old result drains now
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      if (w_accept) begin
        r_op    <= operation;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end else begin
        r_op    <= r_op;
      end
    end
  end

endmodule

// File: tb/tb_elbeth_exu.sv
// Scoreboard bench for elbeth_exu (XLEN = 32, MULDIV_EN = 1).
module tb_elbeth_exu;
  import elbeth_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  operation = 5'd0;
  logic [31:0] data_a = 32'd0;
  logic [31:0] data_b = 32'd0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  always #5 clk = ~clk;

  elbeth_exu #(.XLEN(32), .MULDIV_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .data_a    (data_a),
    .data_b    (data_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pops and compares whenever the DUT hands over a result
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sbq.pop_front();
          check(e.name, result, e.res);
          if (e.cyc >= 0) check({e.name, "_latency"}, cyc, e.cyc);
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string nm,
                       input bit push, output int waits);
    operation = op; data_a = a; data_b = b; in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL %s_accept: in_ready never high within 200 cycles", nm);
    end else if (push) begin
      sbq.push_back('{res: exp, cyc: (lat < 0) ? -1 : cyc + lat, name: nm});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain", sbq.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [4:0]  b2b_op [8] = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL};
  logic [31:0] b2b_a  [8] = '{32'd5, 32'hF0F0_00FF, 32'h0000_0F00, 32'hFFFF_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
  logic [31:0] b2b_b  [8] = '{32'd7, 32'h0FF0_0F0F, 32'h0000_000F, 32'h0F0F_0F0F,
                              32'd1, 32'd1, 32'h24, 32'd31};
  logic [31:0] b2b_e  [8] = '{32'hFFFF_FFFE, 32'h00F0_000F, 32'h0000_0F0F, 32'hF0F0_0F0F,
                              32'd1, 32'd0, 32'h10, 32'd1};

  initial begin
    int w;
    int b0;
    int t;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "add_wrap", 1'b1, w);
    issue(OP_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1, "sra_shamt", 1'b1, w);
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      issue(b2b_op[i], b2b_a[i], b2b_b[i], b2b_e[i], 1, $sformatf("b2b_%0d", i), 1'b1, w);
      check($sformatf("b2b_%0d_no_stall", i), w, 32'd0);
    end
    wait_drain();

    b0 = busy_cnt;
    issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 34, "mulh", 1'b1, w);
    wait_drain();
    check("mulh_busy_cycles", busy_cnt - b0, 32'd33);
    b0 = busy_cnt;
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu", 1'b1, w);
    wait_drain();
    check("mulhu_busy_cycles", busy_cnt - b0, 32'd33);
    issue(OP_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 34, "mul_neg", 1'b1, w);
    wait_drain();
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, "mulhsu", 1'b1, w);
    wait_drain();

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 1'b1, w);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf", 1'b1, w);
    issue(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_zero", 1'b1, w);
    issue(OP_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_zero", 1'b1, w);
    issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_zero", 1'b1, w);
    issue(5'd31, 32'd123, 32'd456, 32'd0, 1, "unknown_op", 1'b1, w);
    wait_drain();
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_neg", 1'b1, w);
    wait_drain();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_neg", 1'b1, w);
    wait_drain();
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu", 1'b1, w);
    wait_drain();
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, 34, "remu", 1'b1, w);
    wait_drain();

    // Backpressure on a MUL result
    out_ready = 1'b0;
    issue(OP_MUL, 32'd3, 32'd5, 32'd15, -1, "mul_bp", 1'b1, w);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      t++;
      @(negedge clk);
    end
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("bp_result_stable", result, 32'd15);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(OP_ADD, 32'd2, 32'd3, 32'd5, 1, "add_after_bp", 1'b1, w);
    check("bp_accept_same_cycle", w, 32'd0);
    wait_drain();

    // Flush in iteration 10 of a divide
    issue(OP_DIVU, 32'd100, 32'd7, 32'd0, -1, "div_flush", 1'b0, w);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    operation = OP_ADD; data_a = 32'd1; data_b = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    check("flush_blocks_input", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (40) @(negedge clk);
    @(posedge clk); #1;

    // Asynchronous reset mid-iteration
    issue(OP_DIV, 32'd100, 32'd7, 32'd0, -1, "div_reset", 1'b0, w);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", {31'd0, out_valid}, 32'd0);
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_result", result, 32'd0);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("areset_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
